// File: rtl/ff_loopback_driver.sv
// Loopback driver/checker for a LAT-cycle registered datapath: drives an
// incrementing sequence, clears the register on TARGET and counts mismatches.
module ff_loopback_driver #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned TARGET = 12,
    parameter int unsigned STEP   = 1,
    parameter int unsigned LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] ff_in,
    output logic             ff_clr_n,
    input  logic [WIDTH-1:0] ff_out,
    output logic             busy,
    output logic             match,
    output logic             done,
    output logic [15:0]      err_cnt,
    output logic [7:0]       wrap_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [WIDTH-1:0] TGT_W      = WIDTH'(TARGET);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [2:0]       FLUSH_LAST = 3'(LAT - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [LAT-1:0]   pipe_v_r;
    logic [WIDTH-1:0] pipe_d_r [LAT];
    logic [2:0]       flush_cnt_r;
    logic             chk_s;
    logic             miss_s;
    logic             hit_s;
    logic             flush_last_s;
    logic             launch_s;

    // Checks only happen on the tail stage while the loop is live.
    assign chk_s        = pipe_v_r[LAT-1] && ((state_r == ST_RUN) || (state_r == ST_FLUSH));
    assign miss_s       = chk_s && (ff_out != pipe_d_r[LAT-1]);
    assign hit_s        = chk_s && (ff_out == pipe_d_r[LAT-1]) && (ff_out == TGT_W);
    assign flush_last_s = (state_r == ST_FLUSH) && (flush_cnt_r == FLUSH_LAST);
    assign launch_s     = (state_r == ST_IDLE) && start;

    // Next-state selection; stop outranks a same-cycle TARGET hit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_FLUSH;
                end else if (hit_s) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, drive outputs and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            ff_in       <= '0;
            ff_clr_n    <= 1'b0;
            busy        <= 1'b0;
            match       <= 1'b0;
            done        <= 1'b0;
            flush_cnt_r <= 3'd0;
        end else begin
            state_r  <= state_nxt_s;
            busy     <= (state_nxt_s != ST_IDLE);
            ff_clr_n <= (state_nxt_s != ST_CLEAR);
            match    <= hit_s;
            done     <= flush_last_s;
            // ff_in only advances on edges that stay in RUN, so it freezes on the way into FLUSH.
            if (state_nxt_s == ST_CLEAR) begin
                ff_in <= '0;
            end else if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) begin
                ff_in <= ff_in + STEP_W;
            end else begin
                ff_in <= ff_in;
            end
            if (state_r == ST_FLUSH) begin
                flush_cnt_r <= flush_cnt_r + 3'd1;
            end else begin
                flush_cnt_r <= 3'd0;
            end
        end
    end

    // Expect pipeline; a pending CLEAR discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_v_r <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                pipe_d_r[i] <= '0;
            end
        end else begin
            pipe_d_r[0] <= ff_in;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_d_r[i] <= pipe_d_r[i-1];
            end
            if ((state_r == ST_CLEAR) || (state_nxt_s == ST_CLEAR)) begin
                pipe_v_r <= '0;
            end else begin
                pipe_v_r[0] <= (state_r == ST_RUN);
                for (int unsigned i = 1; i < LAT; i++) begin
                    pipe_v_r[i] <= pipe_v_r[i-1];
                end
            end
        end
    end

    // Error and TARGET-hit counters, zeroed when a new run is launched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt  <= 16'd0;
            wrap_cnt <= 8'd0;
        end else begin
            if (launch_s) begin
                err_cnt  <= 16'd0;
                wrap_cnt <= 8'd0;
            end else begin
                if (miss_s) begin
                    err_cnt <= sat_inc16(err_cnt);
                end else begin
                    err_cnt <= err_cnt;
                end
                if (hit_s) begin
                    wrap_cnt <= wrap_cnt + 8'd1;
                end else begin
                    wrap_cnt <= wrap_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ff_loopback_driver.sv
// Directed bench: three driver instances (LAT=1 defaults, LAT=2, 4-bit wrap)
// each looped through a behavioural register with an async active-low clear.
module tb_ff_loopback_driver;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: defaults, LAT=1, with an output override for error injection
    logic        a_start = 1'b0, a_stop = 1'b0, a_ovr = 1'b0;
    logic [31:0] a_ff_in, a_ff_out, a_q;
    logic        a_clr_n, a_busy, a_match, a_done;
    logic [15:0] a_err;
    logic [7:0]  a_wrap;

    // Instance B: LAT=2
    logic        b_start = 1'b0, b_stop = 1'b0;
    logic [31:0] b_ff_in, b_ff_out, b_q1, b_q2;
    logic        b_clr_n, b_busy, b_match, b_done;
    logic [15:0] b_err;
    logic [7:0]  b_wrap;

    // Instance C: WIDTH=4, TARGET=3, STEP=5
    logic        c_start = 1'b0, c_stop = 1'b0;
    logic [3:0]  c_ff_in, c_ff_out, c_q;
    logic        c_clr_n, c_busy, c_match, c_done;
    logic [15:0] c_err;
    logic [7:0]  c_wrap;

    ff_loopback_driver #(.WIDTH(32), .TARGET(12), .STEP(1), .LAT(1)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .stop(a_stop),
        .ff_in(a_ff_in), .ff_clr_n(a_clr_n), .ff_out(a_ff_out),
        .busy(a_busy), .match(a_match), .done(a_done),
        .err_cnt(a_err), .wrap_cnt(a_wrap));

    ff_loopback_driver #(.WIDTH(32), .TARGET(12), .STEP(1), .LAT(2)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .stop(b_stop),
        .ff_in(b_ff_in), .ff_clr_n(b_clr_n), .ff_out(b_ff_out),
        .busy(b_busy), .match(b_match), .done(b_done),
        .err_cnt(b_err), .wrap_cnt(b_wrap));

    ff_loopback_driver #(.WIDTH(4), .TARGET(3), .STEP(5), .LAT(1)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .stop(c_stop),
        .ff_in(c_ff_in), .ff_clr_n(c_clr_n), .ff_out(c_ff_out),
        .busy(c_busy), .match(c_match), .done(c_done),
        .err_cnt(c_err), .wrap_cnt(c_wrap));

    always @(posedge clk or negedge a_clr_n) begin
        if (!a_clr_n) a_q <= '0;
        else          a_q <= a_ff_in;
    end
    assign a_ff_out = a_ovr ? 32'h0000_DEAD : a_q;

    always @(posedge clk or negedge b_clr_n) begin
        if (!b_clr_n) begin
            b_q1 <= '0;
            b_q2 <= '0;
        end else begin
            b_q1 <= b_ff_in;
            b_q2 <= b_q1;
        end
    end
    assign b_ff_out = b_q2;

    always @(posedge clk or negedge c_clr_n) begin
        if (!c_clr_n) c_q <= '0;
        else          c_q <= c_ff_in;
    end
    assign c_ff_out = c_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_ff_in !== 32'd0) begin errors++; $display("FAIL rst_ff_in: got %0h expected 0", a_ff_in); end
        checks++; if (a_clr_n !== 1'b0) begin errors++; $display("FAIL rst_clr_n: got %0b expected 0", a_clr_n); end
        checks++; if ({a_busy, a_match, a_done} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %03b expected 000", {a_busy, a_match, a_done}); end
        checks++; if ({a_err, a_wrap} !== 24'd0) begin errors++; $display("FAIL rst_counters: got %0h expected 0", {a_err, a_wrap}); end
        rst = 1'b1;
        tick();
        checks++; if (a_clr_n !== 1'b1) begin errors++; $display("FAIL idle_clr_n: got %0b expected 1", a_clr_n); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", a_busy); end
    endtask

    task automatic test_loop();
        int   low = 0;
        logic exp_m;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++; if ({a_busy, a_clr_n} !== 2'b10) begin errors++; $display("FAIL clear_entry: got busy/clr %02b expected 10", {a_busy, a_clr_n}); end
        for (int e = 1; e <= 60; e++) begin
            tick();
            exp_m = ((e % 15) == 0);
            checks++; if (a_match !== exp_m) begin errors++; $display("FAIL loop_match E%0d: got %0b expected %0b", e, a_match, exp_m); end
            if (e >= 2 && a_clr_n === 1'b0) low++;
            if (e == 13) begin
                checks++; if (a_ff_in !== 32'd12) begin errors++; $display("FAIL loop_ff_in_E13: got %0d expected 12", a_ff_in); end
            end
        end
        checks++; if (a_wrap !== 8'd4) begin errors++; $display("FAIL loop_wrap: got %0d expected 4", a_wrap); end
        checks++; if (a_err !== 16'd0) begin errors++; $display("FAIL loop_err: got %0d expected 0", a_err); end
        checks++; if (low !== 4) begin errors++; $display("FAIL loop_clr_low: got %0d expected 4", low); end
    endtask

    // Continues from E60 of test_loop: E61 starts the next RUN.
    task automatic test_error();
        repeat (3) tick();
        a_ovr = 1'b1;
        tick();
        a_ovr = 1'b0;
        checks++; if (a_err !== 16'd1) begin errors++; $display("FAIL inject_err: got %0d expected 1", a_err); end
        checks++; if (a_match !== 1'b0) begin errors++; $display("FAIL inject_match: got %0b expected 0", a_match); end
        for (int e = 65; e <= 75; e++) begin
            tick();
            checks++; if (a_match !== (e == 75)) begin errors++; $display("FAIL inject_seq_match E%0d: got %0b expected %0b", e, a_match, (e == 75)); end
        end
        checks++; if (a_wrap !== 8'd5) begin errors++; $display("FAIL inject_wrap: got %0d expected 5", a_wrap); end
        checks++; if (a_err !== 16'd1) begin errors++; $display("FAIL inject_err_final: got %0d expected 1", a_err); end
    endtask

    task automatic test_stop_flush();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        repeat (8) tick();
        checks++; if (b_ff_in !== 32'd7) begin errors++; $display("FAIL stop_ff_in_E8: got %0d expected 7", b_ff_in); end
        b_stop = 1'b1;
        tick();
        b_stop = 1'b0;
        checks++; if ({b_busy, b_done} !== 2'b10) begin errors++; $display("FAIL flush_E9: got busy/done %02b expected 10", {b_busy, b_done}); end
        checks++; if (b_ff_in !== 32'd7) begin errors++; $display("FAIL flush_hold: got %0d expected 7", b_ff_in); end
        tick();
        checks++; if ({b_busy, b_done} !== 2'b10) begin errors++; $display("FAIL flush_E10: got busy/done %02b expected 10", {b_busy, b_done}); end
        tick();
        checks++; if ({b_busy, b_done} !== 2'b01) begin errors++; $display("FAIL done_E11: got busy/done %02b expected 01", {b_busy, b_done}); end
        tick();
        checks++; if ({b_busy, b_done} !== 2'b00) begin errors++; $display("FAIL idle_E12: got busy/done %02b expected 00", {b_busy, b_done}); end
        checks++; if (b_ff_in !== 32'd7) begin errors++; $display("FAIL idle_ff_in: got %0d expected 7", b_ff_in); end
        checks++; if ({b_err, b_wrap} !== 24'd0) begin errors++; $display("FAIL stop_counters: got %0h expected 0", {b_err, b_wrap}); end
    endtask

    task automatic test_wrap_step();
        logic [3:0] wexp [0:7];
        wexp = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3};
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (c_ff_in !== wexp[k]) begin errors++; $display("FAIL wrap_seq k=%0d: got %0d expected %0d", k, c_ff_in, wexp[k]); end
        end
        tick();
        checks++; if (c_match !== 1'b0) begin errors++; $display("FAIL wrap_early_match: got %0b expected 0", c_match); end
        tick();
        checks++; if ({c_match, c_clr_n} !== 2'b10) begin errors++; $display("FAIL wrap_hit_E10: got match/clr %02b expected 10", {c_match, c_clr_n}); end
        checks++; if (c_wrap !== 8'd1) begin errors++; $display("FAIL wrap_cnt: got %0d expected 1", c_wrap); end
        checks++; if (c_err !== 16'd0) begin errors++; $display("FAIL wrap_err: got %0d expected 0", c_err); end
    endtask

    task automatic test_saturate();
        a_ovr = 1'b1;
        repeat (70000) tick();
        checks++; if (a_err !== 16'hFFFF) begin errors++; $display("FAIL err_saturate: got %0h expected ffff", a_err); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL sat_busy: got %0b expected 1", a_busy); end
    endtask

    task automatic test_midrun_reset();
        rst = 1'b0;
        #2;
        checks++; if (a_ff_in !== 32'd0) begin errors++; $display("FAIL arst_ff_in: got %0h expected 0", a_ff_in); end
        checks++; if ({a_clr_n, a_busy} !== 2'b00) begin errors++; $display("FAIL arst_clr_busy: got %02b expected 00", {a_clr_n, a_busy}); end
        checks++; if ({a_err, a_wrap} !== 24'd0) begin errors++; $display("FAIL arst_counters: got %0h expected 0", {a_err, a_wrap}); end
        tick();
        rst = 1'b1;
        a_ovr = 1'b0;
        repeat (4) tick();
        checks++; if ({a_busy, a_clr_n} !== 2'b01) begin errors++; $display("FAIL post_rst_idle: got busy/clr %02b expected 01", {a_busy, a_clr_n}); end
        checks++; if (a_ff_in !== 32'd0) begin errors++; $display("FAIL post_rst_ff_in: got %0h expected 0", a_ff_in); end
    endtask

    initial begin
        test_reset();
        test_loop();
        test_error();
        test_stop_flush();
        test_wrap_step();
        test_saturate();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
